// File: rtl/rfc_feature_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : rfc_feature_sequencer
// Brief    : Assembles serial feature words into one datapoint, starts the
//            classifier and returns its label on a valid/ready result port.
// Revision : 1.0 - initial release
// ============================================================================
module rfc_feature_sequencer #(
    parameter int NUM_FEATURES   = 11,
    parameter int FEAT_W         = 32,
    parameter int DONE_GUARD     = 2,
    parameter int LABEL_DELAY    = 1,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [FEAT_W-1:0]                in_data,
    input  logic                             in_last,
    output logic [NUM_FEATURES*FEAT_W-1:0]   feat_bus,
    output logic                             start_traversal,
    input  logic                             done,
    input  logic                             final_label,
    output logic                             res_valid,
    input  logic                             res_ready,
    output logic                             res_label,
    output logic                             res_error,
    output logic                             busy
);

    localparam int c_IDX_W = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1;
    localparam int c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int c_LD_W  = (LABEL_DELAY > 0) ? $clog2(LABEL_DELAY + 1) : 1;

    localparam logic [c_IDX_W-1:0] c_LAST_IDX     = c_IDX_W'(NUM_FEATURES - 1);
    localparam logic [c_CNT_W-1:0] c_GUARD        = c_CNT_W'(DONE_GUARD);
    localparam logic [c_CNT_W-1:0] c_TIMEOUT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [c_LD_W-1:0]  c_LABEL_DELAY  = c_LD_W'(LABEL_DELAY);

    typedef enum logic [2:0] {
        S_LOAD    = 3'd0,
        S_DISCARD = 3'd1,
        S_START   = 3'd2,
        S_WAIT    = 3'd3,
        S_RESULT  = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [c_IDX_W-1:0]  idx_q, idx_d;
    logic [FEAT_W-1:0]   feat_q [NUM_FEATURES];
    logic [FEAT_W-1:0]   feat_d [NUM_FEATURES];
    logic [c_CNT_W-1:0]  cnt_q, cnt_d;
    logic                armed_q, armed_d;
    logic [c_LD_W-1:0]   lab_cnt_q, lab_cnt_d;
    logic                err_pending_q, err_pending_d;
    logic                res_label_q, res_label_d;
    logic                res_error_q, res_error_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_LOAD;
            idx_q         <= '0;
            cnt_q         <= '0;
            armed_q       <= 1'b0;
            lab_cnt_q     <= '0;
            err_pending_q <= 1'b0;
            res_label_q   <= 1'b0;
            res_error_q   <= 1'b0;
            for (int i = 0; i < NUM_FEATURES; i++) begin
                feat_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            cnt_q         <= cnt_d;
            armed_q       <= armed_d;
            lab_cnt_q     <= lab_cnt_d;
            err_pending_q <= err_pending_d;
            res_label_q   <= res_label_d;
            res_error_q   <= res_error_d;
            for (int i = 0; i < NUM_FEATURES; i++) begin
                feat_q[i] <= feat_d[i];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        feat_d        = feat_q;
        cnt_d         = cnt_q;
        armed_d       = armed_q;
        lab_cnt_d     = lab_cnt_q;
        err_pending_d = err_pending_q;
        res_label_d   = res_label_q;
        res_error_d   = res_error_q;

        unique case (state_q)
            S_LOAD: begin
                if (in_valid) begin
                    feat_d[idx_q] = in_data;
                    idx_d         = idx_q + 1'b1;
                    if (idx_q == c_LAST_IDX) begin
                        if (in_last) begin
                            state_d = S_START;
                        end else begin
                            err_pending_d = 1'b1;
                            state_d       = S_DISCARD;
                        end
                    end else if (in_last) begin
                        res_label_d = 1'b0;
                        res_error_d = 1'b1;
                        state_d     = S_RESULT;
                    end
                end
            end

            S_DISCARD: begin
                if (in_valid && in_last) begin
                    res_label_d = 1'b0;
                    res_error_d = err_pending_q;
                    state_d     = S_RESULT;
                end
            end

            S_START: begin
                cnt_d     = '0;
                armed_d   = 1'b0;
                lab_cnt_d = '0;
                state_d   = S_WAIT;
            end

            S_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // Once armed, the label is taken on schedule whatever done does.
                if (armed_q) begin
                    if (lab_cnt_q == c_LABEL_DELAY) begin
                        res_label_d = final_label;
                        res_error_d = 1'b0;
                        state_d     = S_RESULT;
                    end else begin
                        lab_cnt_d = lab_cnt_q + 1'b1;
                    end
                end else if (done && (cnt_q >= c_GUARD)) begin
                    if (LABEL_DELAY == 0) begin
                        res_label_d = final_label;
                        res_error_d = 1'b0;
                        state_d     = S_RESULT;
                    end else begin
                        armed_d   = 1'b1;
                        lab_cnt_d = c_LD_W'(1);
                    end
                end else if (cnt_q == c_TIMEOUT_LAST) begin
                    res_label_d = 1'b0;
                    res_error_d = 1'b1;
                    state_d     = S_RESULT;
                end
            end

            S_RESULT: begin
                if (res_ready) begin
                    idx_d         = '0;
                    err_pending_d = 1'b0;
                    res_label_d   = 1'b0;
                    res_error_d   = 1'b0;
                    state_d       = S_LOAD;
                end
            end

            default: begin
                state_d = S_LOAD;
            end
        endcase
    end

    // Reset masks the state-derived strobes so an aborted frame emits nothing.
    assign in_ready        = ~reset & ((state_q == S_LOAD) | (state_q == S_DISCARD));
    assign start_traversal = ~reset & (state_q == S_START);
    assign res_valid       = ~reset & (state_q == S_RESULT);
    assign busy            = ~reset & ~((state_q == S_LOAD) & (idx_q == '0));
    assign res_label       = res_label_q;
    assign res_error       = res_error_q;

    for (genvar gi = 0; gi < NUM_FEATURES; gi++) begin : g_slot
        assign feat_bus[gi*FEAT_W +: FEAT_W] = feat_q[gi];
    end

endmodule
`default_nettype wire

// File: tb/tb_rfc_feature_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_rfc_feature_sequencer
// Brief    : Randomized scoreboard bench for rfc_feature_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rfc_feature_sequencer;

    localparam int N  = 11;
    localparam int W  = 32;
    localparam int G  = 2;
    localparam int LD = 1;
    localparam int TO = 1024;
    localparam int BW = N * W;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic [W-1:0]  in_data = '0;
    logic          in_last = 1'b0;
    logic          done = 1'b0;
    logic          final_label = 1'b0;
    logic          res_ready = 1'b0;
    logic          in_ready, start_traversal, res_valid, res_label, res_error, busy;
    logic [BW-1:0] feat_bus;

    rfc_feature_sequencer #(
        .NUM_FEATURES   (N),
        .FEAT_W         (W),
        .DONE_GUARD     (G),
        .LABEL_DELAY    (LD),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_data         (in_data),
        .in_last         (in_last),
        .feat_bus        (feat_bus),
        .start_traversal (start_traversal),
        .done            (done),
        .final_label     (final_label),
        .res_valid       (res_valid),
        .res_ready       (res_ready),
        .res_label       (res_label),
        .res_error       (res_error),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        bit            lbl;
        bit            err;
        logic [BW-1:0] feat;
        int            rise;
    } res_t;

    typedef struct {
        int            cyc;
        logic [BW-1:0] feat;
    } st_t;

    res_t exp_q[$];
    st_t  start_q[$];
    logic [W-1:0] mdl_feat [N];

    function automatic logic [BW-1:0] pack_model();
        logic [BW-1:0] v;
        for (int i = 0; i < N; i++) v[i*W +: W] = mdl_feat[i];
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_bus(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input string what);
        n_chk++;
        n_err++;
        $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
    endtask

    // Monitor: compares DUT outputs against the scoreboard queues.
    initial begin
        logic          rst_prev = 1'b1;
        logic          rv_prev = 1'b0, rr_prev = 1'b0, rl_prev = 1'b0, re_prev = 1'b0;
        logic          ir_prev = 1'b0, st_prev = 1'b0, hs_prev = 1'b0;
        logic [BW-1:0] fb_prev = '0;
        st_t           s;
        res_t          e;
        forever begin
            @(negedge clk);
            if (reset) begin
                chk("in_ready_during_reset", 64'(in_ready), 64'd0);
            end else begin
                if (rst_prev) begin
                    chk("rst_in_ready", 64'(in_ready), 64'd1);
                    chk("rst_busy", 64'(busy), 64'd0);
                    chk("rst_res_valid", 64'(res_valid), 64'd0);
                    chk("rst_start", 64'(start_traversal), 64'd0);
                    chk("rst_res_label", 64'(res_label), 64'd0);
                    chk("rst_res_error", 64'(res_error), 64'd0);
                    chk_bus("rst_feat_bus", feat_bus, '0);
                end
                if (start_traversal) begin
                    if (st_prev) fail("start_width", "start pulse longer than one cycle");
                    else if (start_q.size() == 0) fail("start_unexpected", "start pulse with no frame pending");
                    else begin
                        s = start_q.pop_front();
                        chk("start_cycle", 64'(cyc), 64'(s.cyc));
                        chk_bus("start_feat_bus", feat_bus, s.feat);
                        chk("start_busy", 64'(busy), 64'd1);
                    end
                end
                if (!rst_prev && !ir_prev) chk_bus("feat_stable", feat_bus, fb_prev);
                if (!rst_prev && rv_prev && !rr_prev) begin
                    chk("res_valid_hold", 64'(res_valid), 64'd1);
                    chk("res_label_hold", 64'(res_label), 64'(rl_prev));
                    chk("res_error_hold", 64'(res_error), 64'(re_prev));
                end
                if (res_valid) begin
                    chk("in_ready_in_result", 64'(in_ready), 64'd0);
                    if (!rv_prev || rst_prev) begin
                        if (exp_q.size() == 0) fail("result_unexpected", "result with no frame pending");
                        else chk("result_cycle", 64'(cyc), 64'(exp_q[0].rise));
                    end
                    if (res_ready && exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("res_label", 64'(res_label), 64'(e.lbl));
                        chk("res_error", 64'(res_error), 64'(e.err));
                        chk_bus("result_feat_bus", feat_bus, e.feat);
                    end
                end
                if (hs_prev) begin
                    chk("in_ready_after_handshake", 64'(in_ready), 64'd1);
                    chk("busy_after_handshake", 64'(busy), 64'd0);
                end
            end
            hs_prev  = !reset && res_valid && res_ready;
            rst_prev = reset;
            rv_prev  = res_valid;
            rr_prev  = res_ready;
            rl_prev  = res_label;
            re_prev  = res_error;
            ir_prev  = in_ready;
            st_prev  = start_traversal;
            fb_prev  = feat_bus;
        end
    end

    // mode: 0 done level from k_done, 1 stale done then real done at k_done,
    //       2 done never (timeout), 3 reset asserted in WAIT cycle k_done.
    // k indexes WAIT cycles from 0; k=-1 is the start-pulse cycle.
    task automatic send_frame(input int nwords, input int mode, input int k_done,
                              input bit lbl, input int stall, input bit fixed);
        int   t_acc, k_q, k_end, bound;
        res_t e;
        st_t  s;
        t_acc = 0;
        k_end = 0;
        for (int w = 0; w < nwords; w++) begin
            repeat ($urandom_range(0, 2)) begin
                in_valid = 1'b0;
                in_data  = $urandom;
                in_last  = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_data  = fixed ? (32'h10 + w) : $urandom;
            in_last  = (w == nwords - 1);
            if (w < N) mdl_feat[w] = in_data;
            bound = 0;
            while (!in_ready && bound < 50) begin
                @(posedge clk); #1;
                bound++;
            end
            if (!in_ready) fail("in_ready_wait", "word never accepted");
            t_acc = cyc;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;

        if (nwords != N) begin
            e.lbl  = 1'b0;
            e.err  = 1'b1;
            e.feat = pack_model();
            e.rise = t_acc + 1;
            exp_q.push_back(e);
        end else begin
            s.cyc  = t_acc + 1;
            s.feat = pack_model();
            start_q.push_back(s);
            case (mode)
                1:       k_q = k_done;
                2:       k_q = -1;
                default: k_q = (k_done > G) ? k_done : G;
            endcase
            e.feat = pack_model();
            e.lbl  = 1'b0;
            e.err  = 1'b1;
            e.rise = t_acc + 2 + TO;
            if (mode == 2) begin
                k_end = TO - 1;
            end else if (mode == 3) begin
                k_end = k_done;
            end else begin
                e.lbl  = lbl;
                e.err  = 1'b0;
                e.rise = t_acc + 2 + k_q + LD + 1;
                k_end  = k_q + LD;
            end
            if (mode != 3) exp_q.push_back(e);
            for (int j = -1; j <= k_end; j++) begin
                case (mode)
                    1:       done = (j < G) || (j >= k_done);
                    2, 3:    done = 1'b0;
                    default: done = (j >= k_done);
                endcase
                final_label = (j == k_q + LD) ? lbl : ~lbl;
                if (mode == 2 || mode == 3) final_label = 1'($urandom_range(0, 1));
                if (mode == 3 && j == k_done) reset = 1'b1;
                @(posedge clk); #1;
            end
            done        = 1'($urandom_range(0, 1));
            final_label = 1'($urandom_range(0, 1));
            if (mode == 3) begin
                reset = 1'b0;
                for (int i = 0; i < N; i++) mdl_feat[i] = '0;
                repeat (6) @(posedge clk);
                #1;
                return;
            end
        end

        bound = 0;
        while (!res_valid && bound < 40) begin
            @(posedge clk); #1;
            bound++;
        end
        if (!res_valid) begin
            fail("result_wait", "no result presented");
            return;
        end
        repeat (stall) begin
            @(posedge clk); #1;
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
    endtask

    initial begin
        int nw, md, kd;
        for (int i = 0; i < N; i++) mdl_feat[i] = '0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;

        send_frame(N,     0, 4,     1'b1, 0,  1'b1);  // good frame, words 0x10..0x1A
        send_frame(N,     1, G + 3, 1'b0, 1,  1'b0);  // stale done
        send_frame(4,     0, 0,     1'b0, 0,  1'b0);  // short frame
        send_frame(N,     0, 2,     1'b1, 2,  1'b0);
        send_frame(N + 3, 0, 0,     1'b0, 0,  1'b0);  // long frame
        send_frame(N,     2, 0,     1'b0, 10, 1'b0);  // timeout with stalled consumer
        send_frame(N,     3, 5,     1'b0, 0,  1'b0);  // reset mid-WAIT
        send_frame(N,     0, 0,     1'b1, 0,  1'b0);

        for (int f = 0; f < 24; f++) begin
            nw = ($urandom_range(0, 9) < 7) ? N : int'($urandom_range(1, N + 4));
            md = int'($urandom_range(0, 1));
            kd = (md == 1) ? int'($urandom_range(G + 1, G + 8)) : int'($urandom_range(0, 12)) - 1;
            send_frame(nw, md, kd, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 1'b0);
        end

        repeat (5) @(posedge clk);
        #1;
        chk("results_outstanding", 64'(exp_q.size()), 64'd0);
        chk("starts_outstanding", 64'(start_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rfc_feature_sequencer.md
# rfc_feature_sequencer

Upstream sequencer for the random-forest classifier top. Accepts a serial stream of fixed-point feature words, assembles one complete datapoint of NUM_FEATURES words, holds it stable on a flat bus, and pulses `start_traversal`. It then waits for the classifier's `done`, captures `final_label`, and presents the result on a valid/ready output with framing and timeout error reporting.

## Interface

Parameters:
- NUM_FEATURES, 11, number of feature words per datapoint.
- FEAT_W, 32, width of one fixed-point feature word.
- DONE_GUARD, 2, cycles after the start pulse during which `done` is ignored.
- LABEL_DELAY, 1, cycles after the first qualified `done` at which `final_label` is sampled.
- TIMEOUT_CYCLES, 1024, maximum WAIT duration before the frame is failed.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  feature word valid.
- in_ready  out  1  sequencer accepts a word this cycle.
- in_data  in  FEAT_W  feature word; the first word of a frame is feature 0.
- in_last  in  1  marks the last word of a frame.
- feat_bus  out  NUM_FEATURES*FEAT_W  feature i at bits [i*FEAT_W +: FEAT_W].
- start_traversal  out  1  one-cycle start pulse to the classifier.
- done  in  1  classifier done, level.
- final_label  in  1  classifier majority label.
- res_valid  out  1  result available.
- res_ready  in  1  consumer takes the result.
- res_label  out  1  captured label; 0 when res_error=1.
- res_error  out  1  framing error or timeout.
- busy  out  1  high in every state except LOAD with idx=0.

## Operation

- States: LOAD, DISCARD, START, WAIT, RESULT. Reset state is LOAD with idx=0.
- Reset values: in_ready=0 during reset, then 1 from the first cycle in LOAD. feat_bus=0, start_traversal=0, res_valid=0, res_label=0, res_error=0, busy=0. All counters are cleared.
- Reset during any state aborts the frame immediately. No start pulse or result is produced for the aborted frame.
- LOAD:
  - in_ready=1. On in_valid, the word is written into slot idx and idx increments. The width of idx is clog2(NUM_FEATURES).
  - Accepted word at idx=NUM_FEATURES-1 with in_last=1: go to START.
  - Accepted word at idx=NUM_FEATURES-1 with in_last=0: set err_pending and go to DISCARD.
  - Accepted word at idx<NUM_FEATURES-1 with in_last=1 (short frame): go to RESULT with res_error=1, no traversal.
- DISCARD: in_ready=1. Words are accepted and dropped until a word with in_last=1 is accepted, then go to RESULT with res_error=1.
- START: start_traversal=1 for exactly one cycle, in_ready=0, then go to WAIT.
- WAIT:
  - in_ready=0. The wait counter increments every cycle.
  - `done` is ignored for the first DONE_GUARD WAIT cycles, so a stale level is not taken.
  - The first qualified `done` high arms label capture. `final_label` is registered LABEL_DELAY cycles later, independent of the `done` level at that time. Then go to RESULT with res_error=0.
  - If the counter reaches TIMEOUT_CYCLES before a qualified `done`, go to RESULT with res_error=1 and res_label=0.
- RESULT:
  - res_valid=1, and res_label and res_error are held until res_valid && res_ready. On the handshake, go to LOAD, clear idx and err_pending, and drop res_valid.
  - in_ready=0 while in RESULT.
- feat_bus changes only on accepted LOAD writes. It holds stable from START through RESULT and until the next frame's first write.
- `done` or `final_label` activity outside WAIT is ignored.

## Timing

- Throughput in LOAD: one word per cycle. Backpressure is in_ready only.
- The final word is accepted at cycle T.
  - Cycle T+1: START, start_traversal=1.
  - Cycles T+2 through T+1+DONE_GUARD: guard window.
- The first qualified `done` is sampled at cycle D.
  - Cycle D+LABEL_DELAY: final_label is sampled.
  - Cycle D+LABEL_DELAY+1: res_valid=1.
- For a timeout, res_valid rises the cycle after the counter reaches TIMEOUT_CYCLES.
- For a framing error, res_valid rises the cycle after the offending word is accepted.
- The result handshake at cycle H gives in_ready=1 at H+1.
- Minimum frame-to-frame spacing is NUM_FEATURES+DONE_GUARD+LABEL_DELAY+3 cycles.

## Test plan

- Good frame: words 0x10..0x1A, in_last on the 11th, classifier returns done 5 cycles after start with final_label=1. Required: feat_bus slot i = 0x10+i, one start pulse, res_valid with res_label=1 and res_error=0.
- Stale done: `done` held high through START and the guard window, then a real done with final_label=0. Required: the captured label is 0 and the capture comes from the qualified done only.
- Short frame: in_last on the 4th word. Required: no start pulse, res_error=1, res_label=0, next frame accepted normally.
- Long frame: in_last absent on the 11th word and asserted on the 14th. Required: words 12–14 are dropped, res_error=1, feat_bus does not change after word 11.
- Timeout: `done` never asserted. Required: res_error=1 exactly TIMEOUT_CYCLES WAIT cycles after entering WAIT. Then res_ready held low for 10 cycles: res_valid and res_error stay stable, and in_ready stays 0.
- Reset mid-WAIT: reset asserted for 1 cycle. Required: all outputs return to reset values, no result is emitted, in_ready=1 the cycle after reset deasserts.
